lsu_bridge: RTL and testbench
=============================

// Module: lsu_bridge
// PURPOSE
//   Multi-cycle load/store unit between EX and the data-memory bus.
//   - Takes the EX address (ALU_result) and store data (rs2_forward).
//   - Formats byte/half/word accesses and runs a valid/ready bus transaction.
//   - Holds the core with stall until the access completes.
//   - Returns extended load data to WB via mem_data.
// PARAMETERS
//   TIMEOUT   64   cycles allowed in REQ or WAIT before abort; 0 disables the timeout
// PORTS
//   clk          in   1   clock
//   rst          in   1   synchronous, active-high reset
//   mem_read     in   1   load request from decode
//   mem_write    in   1   store request from decode
//   funct3       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (others treated as W)
//   ALU_result   in   32  byte address
//   rs2_forward  in   32  store data
//   mem_data     out  32  registered load result, extended
//   stall        out  1   freeze PC/pipeline while high
//   misalign     out  1   one-cycle misaligned-access flag
//   bus_err      out  1   one-cycle timeout flag
//   bus_valid    out  1   bus request valid
//   bus_ready    in   1   bus accepts request
//   bus_we       out  1   1 = write
//   bus_addr     out  32  word-aligned address ({addr[31:2],2'b00})
//   bus_wdata    out  32  lane-replicated store data
//   bus_wstrb    out  4   byte enables
//   bus_rdata    in   32  read data
//   bus_rvalid   in   1   read data valid; never in the same cycle as acceptance
// BEHAVIOUR
//   Reset values: state IDLE; mem_data, bus_valid, bus_we, bus_wstrb, misalign, bus_err = 0; stall = 0.
//   Timeout counter is cleared on reset.
//   States: IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
//   - IDLE: if mem_read|mem_write, set stall=1 combinationally in the same cycle.
//     Latch addr/funct3/wdata, then go to REQ.
//     If both mem_read and mem_write are high, the read wins and the write is dropped.
//   - REQ: bus_valid=1 with fields held stable until bus_ready.
//     On ready: a write goes to DONE, a read goes to WAIT.
//   - WAIT: on bus_rvalid, capture the formatted load into mem_data, then go to DONE.
//   - DONE: stall=0 for exactly one cycle; inputs are ignored (old instruction); go to IDLE.
//   - stall = 1 in REQ, WAIT, and in IDLE while a request is present; 0 otherwise.
//   Latency (IDLE detect to DONE, zero-wait bus):
//     store 2 stall cycles (3 total); load 3 stall cycles (4 total).
//   Store format:
//     SB: wdata = {4{rs2[7:0]}}, wstrb = 4'b0001 << addr[1:0].
//     SH: wdata = {2{rs2[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
//     SW: wstrb = 1111.
//   Load format: select the lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend.
//   mem_data holds its value until the next load completes.
//   Timeout: the counter resets on entry to REQ and to WAIT.
//     On reaching TIMEOUT: drop bus_valid, mem_data = 0, pulse bus_err in DONE.
//   Reset mid-transaction: abandon the access; bus_valid is 0 from the cycle after the reset edge.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined:
//     - Misaligned accesses are H with addr[0]=1 and W with addr[1:0]!=0.
//     - They issue no bus cycle: IDLE -> DONE directly (one stall cycle).
//     - misalign pulses in DONE; mem_data is cleared to 0 for loads.
//   MISALIGN_TRAP_EN undefined:
//     - Low address bits are truncated to natural alignment (H ignores addr[0], W ignores addr[1:0]).
//     - misalign is tied 0.
// TESTING
//   1. SW addr 0x100, data 0xCAFEBABE, bus_ready=1 immediately
//      -> bus_addr 0x100, wstrb 1111, stall high 2 cycles.
//   2. LB addr 0x203, bus_rdata 0x80000000, rvalid 1 cycle after ready
//      -> mem_data 0xFFFFFF80; LBU same -> 0x00000080; stall 3 cycles.
//   3. SH addr 0x12, rs2 0x1234ABCD -> wdata 0xABCDABCD, wstrb 1100.
//      LHU addr 0x12, rdata 0xBEEF0000 -> mem_data 0x0000BEEF.
//   4. LW addr 0x40 with bus_ready held 0 for TIMEOUT=64 cycles
//      -> bus_err pulses once, mem_data 0, returns to IDLE.
//   5. LW addr 0x42:
//      with MISALIGN_TRAP_EN -> no bus_valid, misalign pulse, 1 stall cycle;
//      without it -> bus_addr 0x40, misalign 0.
//   6. rst asserted in WAIT -> next cycle IDLE, bus_valid 0, stall 0, mem_data 0.
//      Simultaneous mem_read & mem_write -> bus_we 0.

Source files
------------

// File: rtl/lsu_bridge.sv
// lsu_bridge: multi-cycle load/store unit bridging EX to a valid/ready data bus.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of truncating the address.
module lsu_bridge #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALU_result,
    input  logic [31:0] rs2_forward,
    output logic [31:0] mem_data,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid
);

    localparam int unsigned CW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // funct3[1:0] encodes the access size: 00 byte, 01 half, anything else word.
    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = off[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] data;
        case (size)
            2'b00:   data = {4{rs2[7:0]}};
            2'b01:   data = {2{rs2[15:0]}};
            default: data = rs2;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        case (off)
            2'b00:   lane_b = rdata[7:0];
            2'b01:   lane_b = rdata[15:8];
            2'b10:   lane_b = rdata[23:16];
            2'b11:   lane_b = rdata[31:24];
            default: lane_b = 8'h00;
        endcase
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  result = {{24{lane_b[7]}}, lane_b};
            3'b001:  result = {{16{lane_h[15]}}, lane_h};
            3'b100:  result = {24'h000000, lane_b};
            3'b101:  result = {16'h0000, lane_h};
            default: result = rdata;
        endcase
        return result;
    endfunction

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;
    logic        req_s;
    logic        timeout_s;

    assign req_s     = mem_read | mem_write;
    assign timeout_s = (TIMEOUT != 32'd0) && (cnt_q == CW'(TIMEOUT - 32'd1));

`ifdef MISALIGN_TRAP_EN
    logic misaligned_s;

    // Halfwords need an even address, words need a fully aligned one.
    always_comb begin
        if (funct3[1:0] == 2'b01) begin
            misaligned_s = ALU_result[0];
        end else if (funct3[1] == 1'b1) begin
            misaligned_s = (ALU_result[1:0] != 2'b00);
        end else begin
            misaligned_s = 1'b0;
        end
    end
`endif

    // Next-state and next-output logic; stall is the only combinational output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        mem_data_d  = mem_data_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        stall       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    stall       = 1'b1;
                    off_d       = ALU_result[1:0];
                    funct3_d    = funct3;
                    bus_addr_d  = {ALU_result[31:2], 2'b00};
                    // A read beats a simultaneous write; the write is dropped.
                    bus_we_d    = ~mem_read;
                    bus_wdata_d = mem_read ? 32'h0000_0000 : store_data(funct3[1:0], rs2_forward);
                    bus_wstrb_d = mem_read ? 4'b0000 : store_strb(funct3[1:0], ALU_result[1:0]);
                    cnt_d       = {CW{1'b0}};
`ifdef MISALIGN_TRAP_EN
                    if (misaligned_s) begin
                        state_d     = ST_DONE;
                        misalign_d  = 1'b1;
                        bus_valid_d = 1'b0;
                        if (mem_read) begin
                            mem_data_d = 32'h0000_0000;
                        end else begin
                            mem_data_d = mem_data_q;
                        end
                    end else begin
                        state_d     = ST_REQ;
                        bus_valid_d = 1'b1;
                    end
`else
                    state_d     = ST_REQ;
                    bus_valid_d = 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    cnt_d       = {CW{1'b0}};
                    if (bus_we_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (timeout_s) begin
                    bus_valid_d = 1'b0;
                    mem_data_d  = 32'h0000_0000;
                    bus_err_d   = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (bus_rvalid) begin
                    mem_data_d = load_format(funct3_q, off_q, bus_rdata);
                    state_d    = ST_DONE;
                end else if (timeout_s) begin
                    mem_data_d = 32'h0000_0000;
                    bus_err_d  = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                // The instruction still on the inputs has already been served.
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wdata_q <= 32'h0000_0000;
            bus_wstrb_q <= 4'b0000;
            mem_data_q  <= 32'h0000_0000;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            mem_data_q  <= mem_data_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_data  = mem_data_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_lsu_bridge.sv
// tb_lsu_bridge: randomized scoreboard bench for lsu_bridge with a behavioural bus responder.
module tb_lsu_bridge;

    localparam int TO = 64;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        mis;
        logic [31:0] stalls;
    } done_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, rs2_forward, mem_data;
    logic        stall, misalign, bus_err, bus_valid, bus_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;

    int          cfg_d1, cfg_d2;
    bit          cfg_hold, cfg_norv;
    logic [31:0] cfg_rdata;
    logic [31:0] model_mem;

    bus_t  exp_bus[$];
    done_t exp_done[$];
    int    checks = 0;
    int    failures = 0;

    lsu_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .ALU_result(alu_result), .rs2_forward(rs2_forward),
        .mem_data(mem_data), .stall(stall), .misalign(misalign), .bus_err(bus_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // One access: predict bus request and completion, then play the core's side.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rdata, input int d1,
                         input int d2, input bit hold, input bit norv);
        bus_t  eb;
        done_t ed;
        int    sz, off, budget;
        bit    trap;
        logic [31:0] v;
        sz   = size_of(f3);
        off  = (sz == 1) ? int'(addr[1:0]) : (sz == 2) ? int'(addr[1:0]) & 2 : 0;
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
`endif
        eb.addr = addr & 32'hFFFF_FFFC;
        eb.we   = !rd;
        if (sz == 1) begin
            eb.wdata = {4{data[7:0]}};
            eb.wstrb = 4'b0001 << off;
        end else if (sz == 2) begin
            eb.wdata = {2{data[15:0]}};
            eb.wstrb = 4'b0011 << off;
        end else begin
            eb.wdata = data;
            eb.wstrb = 4'b1111;
        end
        v = rdata >> (8 * off);
        if (sz == 1) begin
            v = v & 32'h0000_00FF;
            if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'h0000_FFFF;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        end
        ed.err = 1'b0;
        ed.mis = 1'b0;
        if (trap) begin
            if (rd) model_mem = 32'h0;
            ed.mis = 1'b1;
            ed.stalls = 1;
        end else if (hold) begin
            model_mem = 32'h0;
            ed.err = 1'b1;
            ed.stalls = 32'(1 + TO);
        end else if (rd && norv) begin
            model_mem = 32'h0;
            ed.err = 1'b1;
            ed.stalls = 32'(2 + d1 + TO);
        end else begin
            if (rd) model_mem = v;
            ed.stalls = rd ? 32'(3 + d1 + d2) : 32'(2 + d1);
        end
        ed.data = model_mem;
        if (!trap && !hold) exp_bus.push_back(eb);
        exp_done.push_back(ed);
        cfg_d1 = d1; cfg_d2 = d2; cfg_hold = hold; cfg_norv = norv; cfg_rdata = rdata;
        mem_read = rd; mem_write = wr; funct3 = f3; alu_result = addr; rs2_forward = data;
        for (budget = 0; budget < 300; budget++) begin
            @(posedge clk); #1;
            if (!stall) break;
        end
        if (budget >= 300) begin
            checks++; failures++;
            $display("FAIL done_timeout got=stuck exp=done addr=%h", addr);
        end
        // Request stays on the pins through DONE and must be ignored there.
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        alu_result = $urandom; rs2_forward = $urandom; funct3 = 3'($urandom_range(0, 7));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        cfg_hold = 1'b0; cfg_norv = 1'b0;
    endtask

    task automatic reset_in_wait(input logic [31:0] addr);
        bus_t eb;
        int   budget;
        bit   seen;
        eb.addr = addr & 32'hFFFF_FFFC; eb.we = 1'b0; eb.wdata = 32'h0; eb.wstrb = 4'h0;
        exp_bus.push_back(eb);
        cfg_d1 = 1; cfg_d2 = 0; cfg_hold = 1'b0; cfg_norv = 1'b1;
        mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b010; alu_result = addr;
        seen = 1'b0;
        for (budget = 0; budget < 50; budget++) begin
            @(posedge clk); #1;
            if (bus_valid) seen = 1'b1;
            else if (seen) break;
        end
        if (budget >= 50) begin
            checks++; failures++;
            $display("FAIL reach_wait got=stuck exp=wait");
        end
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; cfg_norv = 1'b0;
        model_mem = 32'h0;
        check32("rst_wait_stall", {31'h0, stall}, 32'h0);
        check32("rst_wait_bus_valid", {31'h0, bus_valid}, 32'h0);
        check32("rst_wait_mem_data", mem_data, 32'h0);
        check32("rst_wait_bus_err", {31'h0, bus_err}, 32'h0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Bus side: grant after cfg_d1 cycles, return read data cfg_d2 cycles after acceptance.
    initial begin : responder
        logic we_l;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (bus_valid && !cfg_hold && !rst) begin
                we_l = bus_we;
                repeat (cfg_d1) begin @(posedge clk); #1; end
                bus_ready = 1'b1;
                @(posedge clk); #1;
                bus_ready = 1'b0;
                if (!we_l && !cfg_norv) begin
                    repeat (cfg_d2) begin @(posedge clk); #1; end
                    bus_rdata = cfg_rdata; bus_rvalid = 1'b1;
                    @(posedge clk); #1;
                    bus_rvalid = 1'b0; bus_rdata = $urandom;
                end
            end
        end
    end

    // Scoreboard: bus handshakes and access completions are checked as they appear.
    initial begin : monitor
        bus_t  eb;
        done_t ed;
        int    run;
        bit    prev;
        run = 0; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0; prev = 1'b0;
            end else begin
                if (bus_valid && bus_ready) begin
                    if (exp_bus.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_bus got=%h exp=none", bus_addr);
                    end else begin
                        eb = exp_bus.pop_front();
                        check32("bus_addr", bus_addr, eb.addr);
                        check32("bus_we", {31'h0, bus_we}, {31'h0, eb.we});
                        if (eb.we) begin
                            check32("bus_wdata", bus_wdata, eb.wdata);
                            check32("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, eb.wstrb});
                        end
                    end
                end
                if (stall) begin
                    run++;
                end else if (prev) begin
                    if (exp_done.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_done got=%h exp=none", mem_data);
                    end else begin
                        ed = exp_done.pop_front();
                        check32("mem_data", mem_data, ed.data);
                        check32("bus_err", {31'h0, bus_err}, {31'h0, ed.err});
                        check32("misalign", {31'h0, misalign}, {31'h0, ed.mis});
                        check32("stall_cycles", 32'(run), ed.stalls);
                    end
                    run = 0;
                end else begin
                    check32("idle_pulses", {30'h0, bus_err, misalign}, 32'h0);
                end
                prev = stall;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit rd, wr;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        alu_result = 32'h0; rs2_forward = 32'h0;
        cfg_d1 = 0; cfg_d2 = 0; cfg_hold = 1'b0; cfg_norv = 1'b0; cfg_rdata = 32'h0;
        model_mem = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_stall", {31'h0, stall}, 32'h0);
        check32("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
        check32("rst_bus_we", {31'h0, bus_we}, 32'h0);
        check32("rst_bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        check32("rst_mem_data", mem_data, 32'h0);
        check32("rst_misalign", {31'h0, misalign}, 32'h0);
        check32("rst_bus_err", {31'h0, bus_err}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hCAFEBABE, 32'h0, 0, 0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h8000_0000, 0, 0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h8000_0000, 0, 0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b001, 32'h12, 32'h1234ABCD, 32'h0, 0, 0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'hBEEF_0000, 0, 0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h5555_AAAA, 0, 0, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h1357_9BDF, 2, 0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'b010, 32'h42, 32'h0, 32'h1122_3344, 1, 1, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'b001, 32'h81, 32'h0, 32'h9876_F00D, 0, 2, 1'b0, 1'b0);
        reset_in_wait(32'h80);
        issue(1'b1, 1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) wr = 1'b1;
            issue(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
        end

        check32("exp_bus_left", 32'(exp_bus.size()), 32'h0);
        check32("exp_done_left", 32'(exp_done.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
